// File: rtl/rom_region_loader.sv
// rom_region_loader
// Routes the HPS ioctl download stream into tagged, word-packed write
// requests. The download starts with a table of 32-bit little-endian region
// lengths; every following byte is assigned to its region, packed into an
// aligned WORD_BYTES-wide word and offered on a single-entry valid/ready
// output register. ioctl_wait mirrors out_valid so the HPS stalls while a
// request is outstanding.
`timescale 1ns/1ps

module rom_region_loader #(
    parameter int                          NUM_REGIONS    = 9,
    parameter int                          WORD_BYTES     = 2,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE    = '0,
    parameter logic [NUM_REGIONS*4-1:0]    REGION_STORAGE = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ioctl_download,
    input  logic                      ioctl_wr,
    input  logic [7:0]                ioctl_dout,
    output logic                      ioctl_wait,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_storage,
    output logic [31:0]               out_addr,
    output logic [8*WORD_BYTES-1:0]   out_data,
    output logic [WORD_BYTES-1:0]     out_be,
    output logic [3:0]                region_idx,
    output logic                      done,
    output logic                      err
);

    // Lane index width; a single-byte word still gets a 1-bit (always zero) lane.
    localparam int                LANE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LANE_MASK  = LANE_W'(WORD_BYTES - 1);
    localparam logic [31:0]       ALIGN_MASK = ~(32'(WORD_BYTES) - 32'd1);
    localparam logic [5:0]        HDR_LAST   = 6'(4 * NUM_REGIONS - 1);
    localparam logic [4:0]        REGION_END = 5'(NUM_REGIONS);

    // S_TAIL is the post-region state: all regions loaded, waiting for the
    // download strobe to fall.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_SKIP   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_TAIL   = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]                state;
    logic                      download_prev;
    logic [5:0]                hdr_cnt;
    logic [4:0]                region_cnt;
    logic [31:0]               offset;
    logic [31:0]               remaining;
    logic [8*WORD_BYTES-1:0]   pack_data;
    logic [WORD_BYTES-1:0]     pack_be;

    // Region length table, filled from the header; sized for the maximum
    // region count so any 4-bit index is in range.
    logic [31:0]               len_mem [16];
    logic [31:0]               base_tab [16];
    logic [3:0]                storage_tab [16];

    logic                      accept;
    logic                      dl_rise;
    logic                      dl_fall;
    logic [LANE_W-1:0]         lane;
    logic [WORD_BYTES-1:0]     lane_hit;
    logic [8*WORD_BYTES-1:0]   pack_data_next;
    logic [WORD_BYTES-1:0]     pack_be_next;
    logic                      word_done;
    logic [31:0]               cur_len;
    logic [31:0]               cur_base;
    logic [3:0]                cur_storage;

    assign ioctl_wait  = out_valid;
    assign accept      = ioctl_wr & ~out_valid;
    assign dl_rise     = ioctl_download & ~download_prev;
    assign dl_fall     = ~ioctl_download & download_prev;
    assign region_idx  = region_cnt[3:0];
    assign lane        = offset[LANE_W-1:0] & LANE_MASK;
    assign word_done   = (lane == LANE_MASK) || (remaining == 32'd1);
    assign cur_len     = len_mem[region_cnt[3:0]];
    assign cur_base    = base_tab[region_cnt[3:0]];
    assign cur_storage = storage_tab[region_cnt[3:0]];

    genvar gi;

    // Unpack the parameter vectors into per-region tables; unused slots read zero.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_region
            if (gi < NUM_REGIONS) begin : g_used
                assign base_tab[gi]    = REGION_BASE[32*gi +: 32];
                assign storage_tab[gi] = REGION_STORAGE[4*gi +: 4];
            end else begin : g_unused
                assign base_tab[gi]    = 32'd0;
                assign storage_tab[gi] = 4'd0;
            end
        end
    endgenerate

    // Packer with the incoming byte merged into its lane.
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign lane_hit[gi]              = (lane == LANE_W'(gi));
            assign pack_data_next[8*gi +: 8] = lane_hit[gi] ? ioctl_dout : pack_data[8*gi +: 8];
            assign pack_be_next[gi]          = pack_be[gi] | lane_hit[gi];
        end
    endgenerate

    // Header capture: byte n of the header lands in region n/4, byte lane n%4.
    always_ff @(posedge clk) begin
        if (state == S_HEADER && accept && !dl_rise && !dl_fall) begin
            len_mem[hdr_cnt[5:2]][8*hdr_cnt[1:0] +: 8] <= ioctl_dout;
        end
    end

    // Load sequencer, packer and single-entry output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            download_prev <= 1'b0;
            hdr_cnt       <= '0;
            region_cnt    <= '0;
            offset        <= '0;
            remaining     <= '0;
            pack_data     <= '0;
            pack_be       <= '0;
            out_valid     <= 1'b0;
            out_storage   <= '0;
            out_addr      <= '0;
            out_data      <= '0;
            out_be        <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            download_prev <= ioctl_download;
            if (dl_rise) begin
                // A new download abandons everything, including a pending request.
                state      <= S_HEADER;
                hdr_cnt    <= '0;
                region_cnt <= '0;
                pack_data  <= '0;
                pack_be    <= '0;
                out_valid  <= 1'b0;
                done       <= 1'b0;
                err        <= 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                case (state)
                    S_HEADER: begin
                        if (dl_fall) begin
                            state <= S_FLUSH;
                            err   <= 1'b1;
                        end else if (accept) begin
                            hdr_cnt <= hdr_cnt + 6'd1;
                            if (hdr_cnt == HDR_LAST) begin
                                state      <= S_SKIP;
                                region_cnt <= '0;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (dl_fall) begin
                            state <= S_FLUSH;
                            err   <= 1'b1;
                        end else begin
                            // A byte strobed while walking the region table has
                            // nowhere to go; flag it rather than lose it silently.
                            if (accept) begin
                                err <= 1'b1;
                            end
                            if (region_cnt == REGION_END) begin
                                state <= S_TAIL;
                            end else if (cur_len == 32'd0) begin
                                region_cnt <= region_cnt + 5'd1;
                            end else begin
                                remaining <= cur_len;
                                offset    <= '0;
                                state     <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (dl_fall) begin
                            state <= S_FLUSH;
                            err   <= 1'b1;
                        end else if (accept) begin
                            offset    <= offset + 32'd1;
                            remaining <= remaining - 32'd1;
                            if (word_done) begin
                                out_valid   <= 1'b1;
                                out_addr    <= cur_base + (offset & ALIGN_MASK);
                                out_data    <= pack_data_next;
                                out_be      <= pack_be_next;
                                out_storage <= cur_storage;
                                pack_data   <= '0;
                                pack_be     <= '0;
                            end else begin
                                pack_data <= pack_data_next;
                                pack_be   <= pack_be_next;
                            end
                            if (remaining == 32'd1) begin
                                region_cnt <= region_cnt + 5'd1;
                                state      <= S_SKIP;
                            end
                        end
                    end
                    S_TAIL: begin
                        if (dl_fall) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (accept) begin
                            err <= 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        // Wait for the output register, emit any partial word,
                        // then finish once nothing is left outstanding.
                        if (!out_valid || out_ready) begin
                            if (pack_be != '0) begin
                                out_valid   <= 1'b1;
                                out_addr    <= cur_base + (offset & ALIGN_MASK);
                                out_data    <= pack_data;
                                out_be      <= pack_be;
                                out_storage <= cur_storage;
                                pack_data   <= '0;
                                pack_be     <= '0;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_IDLE, S_DONE: begin
                        state <= state;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rom_region_loader.md
# rom_region_loader

Parametrised ROM download router sitting between the HPS ioctl byte stream and the SDR/DDR/block-RAM write ports. It generalises the fixed load-region table into a parameter set with a configurable region count, output word width and per-region storage target. It parses a length header at the start of the download and assigns each following byte to its region. Bytes are packed into aligned words and emitted as tagged write requests through a valid/ready handshake, with partial-word flush, zero-length-region skip and overrun/truncation detection.

## Interface

Parameters:
- NUM_REGIONS, 9: number of load regions; legal range 1–16.
- WORD_BYTES, 2: output word width in bytes; legal values 1, 2, 4, 8.
- REGION_BASE, 0: packed vector of NUM_REGIONS×32 bits; entry i is at [32i+31:32i]. Each base is the region's absolute byte base and is WORD_BYTES-aligned.
- REGION_STORAGE, 0: packed vector of NUM_REGIONS×4 bits. Entry values: 0 = SDR, 1 = DDR, 2 = BLOCK.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- ioctl_download, in, 1: download active (level).
- ioctl_wr, in, 1: byte strobe.
- ioctl_dout, in, 8: byte data.
- ioctl_wait, out, 1: stall request to the HPS.
- out_valid, out, 1: write request valid.
- out_ready, in, 1: sink accepts the request.
- out_storage, out, 4: storage tag of the target region.
- out_addr, out, 32: byte address, WORD_BYTES-aligned.
- out_data, out, 8×WORD_BYTES: data word; byte k goes to out_addr+k.
- out_be, out, WORD_BYTES: byte enables.
- region_idx, out, 4: current region.
- done, out, 1: load completed; sticky until the next download.
- err, out, 1: overrun or truncation; sticky until the next download.

## Operation

- States: IDLE, HEADER, SKIP, DATA, FLUSH, DONE.
- A byte is accepted on a cycle where ioctl_wr=1 and ioctl_wait=0.
- ioctl_wait equals out_valid; the output register is single-entry.
- Rising edge of ioctl_download, from any state:
  - go to HEADER;
  - clear done, err, region_idx, the header byte counter, the packer and out_valid. A pending request is dropped.

HEADER:
- Receives 4×NUM_REGIONS bytes: 32-bit little-endian lengths, region 0 first, stored in an internal length array.
- After the last header byte, go to SKIP with region_idx=0.

SKIP:
- If len[region_idx]==0, increment region_idx; this takes one cycle per empty region.
- If region_idx reaches NUM_REGIONS, go to DONE-wait with no data expected.
- Otherwise load remaining=len and offset=0, then go to DATA.

DATA:
- Each accepted byte goes into lane offset[log2(WORD_BYTES)-1:0] of the packer and sets that lane's enable bit.
- Then offset+=1 and remaining-=1.
- When the lane is WORD_BYTES-1, or remaining reaches 0, load the output register:
  - out_addr = base + (offset_before & ~(WORD_BYTES-1));
  - out_be = accumulated enables;
  - out_storage = REGION_STORAGE[region_idx];
  - then clear the packer.
- When remaining reaches 0, increment region_idx and return to SKIP.
- Bytes accepted after all regions are complete are dropped and set err.

Falling edge of ioctl_download:
- From DATA or HEADER, go to FLUSH and set err, because the load is truncated.
- From the post-region state, go directly to DONE.

FLUSH:
- Emits any nonzero partial packer as a final request, then goes to DONE.

DONE:
- done=1. No further requests are issued.

Arithmetic:
- Offset and remaining are 32-bit.
- Address addition is modulo 2^32.

## Timing

- Reset values: ioctl_wait=0, out_valid=0, out_storage=0, out_addr=0, out_data=0, out_be=0, region_idx=0, done=0, err=0. State is IDLE.
- Latency: out_valid asserts on the cycle after the byte that completes a word is accepted.
- out_valid holds, with all payload fields stable, until the cycle where out_valid&out_ready; it deasserts on the next edge.
- Throughput: at most one request per two cycles, since ioctl_wait blocks the stream while a request is pending.
- A completed partial word at region end has the same 1-cycle latency as a full word.
- done rises one cycle after FLUSH completes its handshake, or one cycle after the falling edge if nothing is pending.
- A download restart in the same cycle as a pending handshake: the restart wins and the request is discarded.

## Test plan

- NUM_REGIONS=3, WORD_BYTES=2, bases {0x0000_0000, 0x0090_0000, 0x3810_0000}, storage {0,0,1}, lengths {4,3,2}, data bytes 0x10..0x18, out_ready=1 → requests in order:
  - (0,0x0000_0000,0x1110,be=11);
  - (0,0x0000_0002,0x1312,11);
  - (0,0x0090_0000,0x1514,11);
  - (0,0x0090_0002,0x0016,01);
  - (1,0x3810_0000,0x1817,11);
  - then done=1, err=0.
- Lengths {0,0,3}: no requests for regions 0/1; region_idx goes 0→1→2 over two SKIP cycles; the first request targets 0x3810_0000.
- out_ready=0 for 10 cycles during region 0: ioctl_wait=1 throughout, out_addr/out_data stable, no byte lost. After release the sequence matches the first scenario.
- Lengths {4,3,2} with 3 extra bytes: exactly the 5 requests of the first scenario, err=1, done=1.
- ioctl_download drops after 5 data bytes: FLUSH emits (0,0x0090_0000,0x0014,be=01), then err=1, done=1.
- Re-assert ioctl_download while out_valid=1: out_valid=0 next cycle, done/err cleared, HEADER restarts cleanly.
